// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: FSM state encoding and the default tick divider.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_LAP   = 2'd2,
      ST_PAUSE = 2'd3
   } state_t;

   // 50 MHz core clock down to the 1/100 s count rate; the time counter uses it too
   localparam int CLK_DIV_DEFAULT = 500000;

endpackage

// File: rtl/key_edge.sv
// Raw key to one-cycle press pulse: 2-flop synchronizer plus rising-edge detect.
// press is high in the cycle after the second sampling edge; no backpressure.
module key_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic key_async,
   output logic press
);

   logic sync1, sync2, sync_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1  <= 1'b0;
         sync2  <= 1'b0;
         sync_d <= 1'b0;
      end else begin
         sync1  <= key_async;
         sync2  <= sync1;
         sync_d <= sync2;
      end
   end

   // flops clear to 0, so a key held through reset release still yields one press
   assign press = sync2 & ~sync_d;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch mode sequencer: run/pause/lap/clear FSM, tick prescaler, registered outputs.
// Outputs update two edges after a key is first sampled high; no backpressure.
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       key_ss_async,
   input  logic       key_lr_async,
   output logic       tick,
   output logic       clr,
   output logic       hold,
   output logic [1:0] state
);

   localparam int            CW      = $clog2(CLK_DIV);
   localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

   logic          ss_press, lr_press;
   state_t        cur, nxt;
   logic          clr_nxt;
   logic          counting;
   logic [CW-1:0] cnt;

   key_edge u_key_ss (.clk(clk), .rst_n(rst_n), .key_async(key_ss_async), .press(ss_press));
   key_edge u_key_lr (.clk(clk), .rst_n(rst_n), .key_async(key_lr_async), .press(lr_press));

   // ss is tested first everywhere, so a same-cycle lr press is dropped
   always_comb begin
      nxt     = cur;
      clr_nxt = 1'b0;
      case (cur)
         ST_IDLE: begin
            if (ss_press)      nxt = ST_RUN;
            else if (lr_press) clr_nxt = 1'b1;
         end
         ST_RUN: begin
            if (ss_press)      nxt = ST_PAUSE;
            else if (lr_press) nxt = ST_LAP;
         end
         ST_LAP: begin
            if (ss_press)      nxt = ST_PAUSE;
            else if (lr_press) nxt = ST_RUN;
         end
         ST_PAUSE: begin
            if (ss_press) nxt = ST_RUN;
            else if (lr_press) begin
               nxt     = ST_IDLE;
               clr_nxt = 1'b1;
            end
         end
         default: nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur  <= ST_IDLE;
         clr  <= 1'b0;
         hold <= 1'b0;
      end else begin
         cur  <= nxt;
         clr  <= clr_nxt;
         hold <= (nxt == ST_LAP);
      end
   end

   // Counting follows the current state, so a wrap on the pause edge still ticks
   // and a paused count resumes where it left off.
   assign counting = (cur == ST_RUN) || (cur == ST_LAP);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else if (clr_nxt) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else if (counting) begin
         if (cnt == CNT_MAX) begin
            cnt  <= '0;
            tick <= 1'b1;
         end else begin
            cnt  <= cnt + CW'(1);
            tick <= 1'b0;
         end
      end else begin
         tick <= 1'b0;
      end
   end

   assign state = cur;

endmodule
